// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Each operation is accepted, executed for one cycle, then returned on a tagged response channel.
module alu_rr_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,

    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SEL_W-1:0] op_sel;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    // Grants are gated by rst_n so ready stays low while reset is asserted.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_n) begin
                    grant0 = req0_valid && (!req1_valid || !ptr);
                    grant1 = req1_valid && (!req0_valid ||  ptr);
                    if (grant0 || grant1) begin
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                op_a   <= grant1 ? req1_a   : req0_a;
                op_b   <= grant1 ? req1_b   : req0_b;
                op_sel <= grant1 ? req1_sel : req0_sel;
                id_q   <= grant1;
            end
            if (state == S_EXEC) begin
                result_q <= alu_out;
                carry_q  <= alu_carry;
            end
            // Priority moves to the other requester only when a response completes.
            if (state == S_RESP && rsp_ready) begin
                ptr <= ~id_q;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_sel    = op_sel;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter; a behavioural 16-bit ALU model closes the datapath loop.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [15:0] rsp_result;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_carry;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(16), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .busy(busy)
    );

    // Reference ALU: CarryOut is always the carry of A+B, independent of the select.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = alu_sum[16];
        case (alu_sel)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = alu_a * alu_b;
            4'd3:    alu_out = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
            4'd4:    alu_out = alu_a << 1;
            4'd5:    alu_out = alu_a >> 1;
            4'd6:    alu_out = {alu_a[14:0], alu_a[15]};
            4'd7:    alu_out = {alu_a[0], alu_a[15:1]};
            4'd8:    alu_out = alu_a & alu_b;
            4'd9:    alu_out = alu_a | alu_b;
            4'd10:   alu_out = alu_a ^ alu_b;
            4'd11:   alu_out = ~(alu_a | alu_b);
            4'd12:   alu_out = ~(alu_a & alu_b);
            4'd13:   alu_out = ~(alu_a ^ alu_b);
            4'd14:   alu_out = (alu_a > alu_b) ? 16'd1 : 16'd0;
            default: alu_out = (alu_a == alu_b) ? 16'd1 : 16'd0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req0_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, busy});
        end
        checks++;
        if ({rsp_result, alu_a, alu_b, alu_sel} !== 52'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {rsp_result, alu_a, alu_b, alu_sel});
        end
        req0_valid = 1'b0;
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_req0();
        clear_inputs();
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h00FA; req0_b = 16'h0002; req0_sel = 4'd0;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL t1_cycle0 got=%b exp=1000", {req0_ready, req1_ready, busy, rsp_valid});
        end
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, req0_ready} !== 3'b100 || alu_a !== 16'h00FA || alu_b !== 16'h0002 || alu_sel !== 4'd0) begin
            failures++;
            $display("FAIL t1_exec got=%b a=%h b=%h sel=%h exp=100 a=00fa b=0002 sel=0", {busy, rsp_valid, req0_ready}, alu_a, alu_b, alu_sel);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h00FC || rsp_carry !== 1'b0) begin
            failures++;
            $display("FAIL t1_rsp got v=%b id=%b r=%h c=%b exp v=1 id=0 r=00fc c=0", rsp_valid, rsp_id, rsp_result, rsp_carry);
        end
        step();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL t1_idle got=%b exp=00", {rsp_valid, busy});
        end
    endtask

    task automatic test_single_req1();
        clear_inputs();
        do_reset();
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; req1_sel = 4'd0;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL t2_grant got=%b exp=01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h0000 || rsp_carry !== 1'b1) begin
            failures++;
            $display("FAIL t2_rsp got v=%b id=%b r=%h c=%b exp v=1 id=1 r=0000 c=1", rsp_valid, rsp_id, rsp_result, rsp_carry);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [15:0] exp_r;
        logic        exp_c;
        clear_inputs();
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_sel = 4'd0;
        req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8001; req1_sel = 4'd1;
        rsp_ready  = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 1);
            exp_r  = exp_id ? 16'hFFFF : 16'h2345;
            exp_c  = exp_id;
            checks++;
            if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
                failures++;
                $display("FAIL t3_grant k=%0d got=%b exp=%b", k, {req0_ready, req1_ready}, {~exp_id, exp_id});
            end
            step();
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_r || rsp_carry !== exp_c) begin
                failures++;
                $display("FAIL t3_rsp k=%0d got v=%b id=%b r=%h c=%b exp v=1 id=%b r=%h c=%b", k, rsp_valid, rsp_id, rsp_result, rsp_carry, exp_id, exp_r, exp_c);
            end
            step();
        end
    endtask

    task automatic test_rsp_stall();
        clear_inputs();
        req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0003; req0_sel = 4'd2;
        req1_valid = 1'b1; req1_a = 16'h00F0; req1_b = 16'h0FF0; req1_sel = 4'd8;
        do_reset();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_carry, busy, req0_ready, req1_ready} !== 6'b100100 || rsp_result !== 16'h000F) begin
                failures++;
                $display("FAIL t4_stall k=%0d got=%b r=%h exp=100100 r=000f", k, {rsp_valid, rsp_id, rsp_carry, busy, req0_ready, req1_ready}, rsp_result);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
            failures++;
            $display("FAIL t4_complete got=%b exp=100", {rsp_valid, req0_ready, req1_ready});
        end
        step();
        checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b001) begin
            failures++;
            $display("FAIL t4_next_grant got=%b exp=001", {busy, req0_ready, req1_ready});
        end
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h00F0 || rsp_carry !== 1'b0) begin
            failures++;
            $display("FAIL t4_rsp1 got v=%b id=%b r=%h c=%b exp v=1 id=1 r=00f0 c=0", rsp_valid, rsp_id, rsp_result, rsp_carry);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        clear_inputs();
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_sel = 4'd0;
        rsp_ready  = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        step();
        req0_valid = 1'b1; req0_a = 16'h0020; req0_b = 16'h0004; req0_sel = 4'd3;
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003; req1_sel = 4'd9;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL t5_ptr_before got=%b exp=01", {req0_ready, req1_ready});
        end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_carry} !== 6'b0 || {rsp_result, alu_a, alu_b, alu_sel} !== 52'd0) begin
            failures++;
            $display("FAIL t5_async got=%b data=%h exp=000000 data=0", {rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_carry}, {rsp_result, alu_a, alu_b, alu_sel});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL t5_ptr_after got=%b exp=10", {req0_ready, req1_ready});
        end
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h0008 || rsp_carry !== 1'b0) begin
            failures++;
            $display("FAIL t5_rsp got v=%b id=%b r=%h c=%b exp v=1 id=0 r=0008 c=0", rsp_valid, rsp_id, rsp_result, rsp_carry);
        end
        step();
    endtask

    task automatic test_sel_sweep();
        logic [15:0] exp_r [8];
        exp_r = '{16'h00FC, 16'h00F8, 16'h01F4, 16'h007D, 16'h01F4, 16'h007D, 16'h01F4, 16'h007D};
        clear_inputs();
        do_reset();
        rsp_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            req0_valid = 1'b1; req0_a = 16'h00FA; req0_b = 16'h0002; req0_sel = 4'(s);
            step();
            req0_valid = 1'b0;
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_r[s] || rsp_carry !== 1'b0) begin
                failures++;
                $display("FAIL t6_sel%0d got v=%b r=%h c=%b exp v=1 r=%h c=0", s, rsp_valid, rsp_result, rsp_carry, exp_r[s]);
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_req0();
        test_single_req1();
        test_round_robin();
        test_rsp_stall();
        test_reset_mid_op();
        test_sel_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
